// File: rtl/ps2_calc_pkg.sv
// Purpose : shared key encodings, scan-code constants, decoder FSM states and
//           the Set-2 scan-code to calculator-key lookup functions.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ps2_calc_pkg;

   localparam int KEY_W = 5;

   localparam logic [KEY_W-1:0] KEY_0    = 5'd0;
   localparam logic [KEY_W-1:0] KEY_1    = 5'd1;
   localparam logic [KEY_W-1:0] KEY_2    = 5'd2;
   localparam logic [KEY_W-1:0] KEY_3    = 5'd3;
   localparam logic [KEY_W-1:0] KEY_4    = 5'd4;
   localparam logic [KEY_W-1:0] KEY_5    = 5'd5;
   localparam logic [KEY_W-1:0] KEY_6    = 5'd6;
   localparam logic [KEY_W-1:0] KEY_7    = 5'd7;
   localparam logic [KEY_W-1:0] KEY_8    = 5'd8;
   localparam logic [KEY_W-1:0] KEY_9    = 5'd9;
   localparam logic [KEY_W-1:0] KEY_ADD  = 5'd10;
   localparam logic [KEY_W-1:0] KEY_SUB  = 5'd11;
   localparam logic [KEY_W-1:0] KEY_MUL  = 5'd12;
   localparam logic [KEY_W-1:0] KEY_DIV  = 5'd13;
   localparam logic [KEY_W-1:0] KEY_EQ   = 5'd14;
   localparam logic [KEY_W-1:0] KEY_BKSP = 5'd15;
   localparam logic [KEY_W-1:0] KEY_CLR  = 5'd16;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   typedef struct packed {
      logic             hit;
      logic [KEY_W-1:0] key;
   } key_map_t;

   // Keyboard status/handshake bytes that can appear between scan codes;
   // they abandon any partial prefix sequence.
   function automatic logic is_ctrl(input logic [7:0] sc);
      return (sc == 8'hAA) || (sc == 8'hFA) || (sc == 8'hEE) ||
             (sc == 8'hFE) || (sc == 8'hFF) || (sc == 8'h00);
   endfunction

   function automatic logic is_shift(input logic [7:0] sc);
      return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
   endfunction

   // Main-block keys. Shift only changes '=' (to '+') and '8' (to '*').
   function automatic key_map_t map_main(input logic [7:0] sc, input logic shift);
      key_map_t m;
      m.hit = 1'b1;
      m.key = KEY_0;
      case (sc)
         8'h45: m.key = KEY_0;
         8'h16: m.key = KEY_1;
         8'h1E: m.key = KEY_2;
         8'h26: m.key = KEY_3;
         8'h25: m.key = KEY_4;
         8'h2E: m.key = KEY_5;
         8'h36: m.key = KEY_6;
         8'h3D: m.key = KEY_7;
         8'h3E: m.key = shift ? KEY_MUL : KEY_8;
         8'h46: m.key = KEY_9;
         8'h4E: m.key = KEY_SUB;
         8'h4A: m.key = KEY_DIV;
         8'h5A: m.key = KEY_EQ;
         8'h55: m.key = shift ? KEY_ADD : KEY_EQ;
         8'h66: m.key = KEY_BKSP;
         8'h76: m.key = KEY_CLR;
         default: m.hit = 1'b0;
      endcase
      return m;
   endfunction

   // Numeric keypad, unprefixed codes.
   function automatic key_map_t map_numpad(input logic [7:0] sc);
      key_map_t m;
      m.hit = 1'b1;
      m.key = KEY_0;
      case (sc)
         8'h70: m.key = KEY_0;
         8'h69: m.key = KEY_1;
         8'h72: m.key = KEY_2;
         8'h7A: m.key = KEY_3;
         8'h6B: m.key = KEY_4;
         8'h73: m.key = KEY_5;
         8'h74: m.key = KEY_6;
         8'h6C: m.key = KEY_7;
         8'h75: m.key = KEY_8;
         8'h7D: m.key = KEY_9;
         8'h79: m.key = KEY_ADD;
         8'h7B: m.key = KEY_SUB;
         8'h7C: m.key = KEY_MUL;
         default: m.hit = 1'b0;
      endcase
      return m;
   endfunction

   // Numeric keypad, E0-prefixed codes (keypad '/' and Enter).
   function automatic key_map_t map_ext(input logic [7:0] sc);
      key_map_t m;
      m.hit = 1'b1;
      m.key = KEY_0;
      case (sc)
         8'h4A: m.key = KEY_DIV;
         8'h5A: m.key = KEY_EQ;
         default: m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_key_fifo.sv
// Purpose : first-word-fall-through FIFO holding decoded keys.
// Latency : a push at edge N is visible on valid/data right after edge N.
// Backpressure: push is accepted when not full or when a pop happens in the
//           same cycle; otherwise it is ignored (caller watches 'full').
// Ports   : clk, rst (async, active-high); push/push_data in; full out;
//           pop in (ignored while empty); valid/data out (data=0 when empty).
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             empty;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign valid   = ~empty;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Purpose : turns PS/2 Set-2 scan codes into calculator key events; tracks
//           F0/E0 prefixes and shift, queues keys in a FWFT FIFO.
//           Optional macro PS2_DEC_NUMPAD_EN adds numeric keypad decoding.
// Latency : strobe at edge N -> key written at edge N+1 -> key_valid after N+1.
// Backpressure: key_valid/key_ready handshake; a key arriving at a full FIFO
//           with no pop is dropped and sets sticky overflow.
// Ports   : clk, rst (async, active-high); code_valid/code_data in;
//           key_valid/key_code out, key_ready in; overflow out.
module ps2_key_decoder
   import ps2_calc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             code_valid,
   input  logic [7:0]       code_data,
   output logic             key_valid,
   output logic [KEY_W-1:0] key_code,
   input  logic             key_ready,
   output logic             overflow
);

   state_t           state_q, state_d;
   logic             shift_q, shift_d;
   logic             push_q, push_d;
   logic [KEY_W-1:0] push_key_q, push_key_d;
   logic             overflow_q, overflow_d;
   logic             fifo_full;
   logic             pop;
   key_map_t         dec;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      dec        = '0;
      if (code_valid) begin
         if (is_ctrl(code_data)) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (code_data == SC_BRK) begin
                     state_d = BRK;
                  end else if (code_data == SC_EXT) begin
                     state_d = EXT;
                  end else begin
                     if (is_shift(code_data)) begin
                        shift_d = 1'b1;
                     end
                     // Uses the shift state from before this byte.
                     dec = map_main(code_data, shift_q);
`ifdef PS2_DEC_NUMPAD_EN
                     if (!dec.hit) begin
                        dec = map_numpad(code_data);
                     end
`endif
                  end
               end
               BRK: begin
                  if (is_shift(code_data)) begin
                     shift_d = 1'b0;
                  end
                  state_d = IDLE;
               end
               EXT: begin
                  if (code_data == SC_BRK) begin
                     state_d = EXT_BRK;
                  end else begin
`ifdef PS2_DEC_NUMPAD_EN
                     dec = map_ext(code_data);
`endif
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
      push_d     = dec.hit;
      push_key_d = dec.key;
   end

   assign pop        = key_valid & key_ready;
   // A pop in the same cycle frees the slot, so the key is not lost.
   assign overflow_d = overflow_q | (push_q & fifo_full & ~pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= 1'b0;
         push_q     <= 1'b0;
         push_key_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         push_q     <= push_d;
         push_key_q <= push_key_d;
         overflow_q <= overflow_d;
      end
   end

   key_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KEY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (push_key_q),
      .full      (fifo_full),
      .pop       (key_ready),
      .valid     (key_valid),
      .data      (key_code)
   );

   assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       code_valid;
   logic [7:0] code_data;
   logic       key_valid;
   logic [4:0] key_code;
   logic       key_ready;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   ps2_key_decoder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code_data  (code_data),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] kp_sc  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                              8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   bit m_brk, m_ext, m_shift, m_ovf, m_pend;
   int m_pend_key;
   int mq[$];

   function automatic int lut_main(input logic [7:0] b, input bit sh);
      for (int i = 0; i < 10; i++) begin
         if (b == dig_sc[i]) return (i == 8 && sh) ? 12 : i;
      end
      if (b == 8'h4E) return 11;
      if (b == 8'h4A) return 13;
      if (b == 8'h5A) return 14;
      if (b == 8'h66) return 15;
      if (b == 8'h76) return 16;
      if (b == 8'h55) return sh ? 10 : 14;
      return -1;
   endfunction

   function automatic int lut_kp(input logic [7:0] b);
`ifdef PS2_DEC_NUMPAD_EN
      for (int i = 0; i < 10; i++) begin
         if (b == kp_sc[i]) return i;
      end
      if (b == 8'h79) return 10;
      if (b == 8'h7B) return 11;
      if (b == 8'h7C) return 12;
`endif
      return -1;
   endfunction

   function automatic int lut_ext(input logic [7:0] b);
`ifdef PS2_DEC_NUMPAD_EN
      if (b == 8'h4A) return 13;
      if (b == 8'h5A) return 14;
`endif
      return -1;
   endfunction

   // Returns the key a received byte produces, or -1.
   function automatic int model_decode(input logic [7:0] b);
      int k;
      k = -1;
      if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00}) begin
         m_brk = 0;
         m_ext = 0;
      end else if (!m_brk && !m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE0) m_ext = 1;
         else begin
            k = lut_main(b, m_shift);
            if (k < 0) k = lut_kp(b);
            if (b == 8'h12 || b == 8'h59) m_shift = 1;
         end
      end else if (m_brk && !m_ext) begin
         if (b == 8'h12 || b == 8'h59) m_shift = 0;
         m_brk = 0;
      end else if (m_ext && !m_brk) begin
         if (b == 8'hF0) m_brk = 1;
         else begin
            k = lut_ext(b);
            m_ext = 0;
         end
      end else begin
         m_brk = 0;
         m_ext = 0;
      end
      return k;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_brk   = 0;
         m_ext   = 0;
         m_shift = 0;
         m_ovf   = 0;
         m_pend  = 0;
         mq.delete();
      end else begin
         int k;
         if (mq.size() > 0 && key_ready) void'(mq.pop_front());
         if (m_pend) begin
            if (mq.size() < DEPTH) mq.push_back(m_pend_key);
            else m_ovf = 1;
         end
         m_pend = 0;
         if (code_valid) begin
            k = model_decode(code_data);
            if (k >= 0) begin
               m_pend     = 1;
               m_pend_key = k;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_key_valid", int'(key_valid), int'(mq.size() > 0));
      if (mq.size() > 0) chk("model_key_code", int'(key_code), mq[0]);
      chk("model_overflow", int'(overflow), int'(m_ovf));
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      code_valid = 1'b1;
      code_data  = b;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
   endtask

   task automatic pop_one();
      key_ready = 1'b1;
      @(posedge clk);
      #1;
      key_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [7:0] pick_byte();
      logic [7:0] main_pool [17] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                     8'h36, 8'h3D, 8'h3E, 8'h46, 8'h4E, 8'h4A,
                                     8'h5A, 8'h66, 8'h76, 8'h55, 8'hE1};
      logic [7:0] ctrl_pool [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00};
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return main_pool[$urandom_range(0, 16)];
         4:          return 8'hF0;
         5:          return 8'hE0;
         6:          return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
         7:          return ctrl_pool[$urandom_range(0, 5)];
         8:          return kp_sc[$urandom_range(0, 9)];
         default:    return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      rst        = 1'b1;
      code_valid = 1'b0;
      code_data  = 8'h00;
      key_ready  = 1'b0;
      idle(2);
      chk("reset_key_valid", int'(key_valid), 0);
      chk("reset_key_code", int'(key_code), 0);
      chk("reset_overflow", int'(overflow), 0);
      rst = 1'b0;
      idle(1);

      // Make, release of '1': one key with one cycle of latency.
      send(8'h16);
      chk("t1_latency_low", int'(key_valid), 0);
      idle(1);
      chk("t1_valid", int'(key_valid), 1);
      chk("t1_code", int'(key_code), 1);
      send(8'hF0);
      send(8'h16);
      idle(2);
      pop_one();
      chk("t1_single_key", int'(key_valid), 0);

      // Shift+'=' gives ADD, after shift release '=' gives EQ.
      send(8'h12); send(8'h55); send(8'hF0); send(8'h55);
      send(8'hF0); send(8'h12); send(8'h55);
      idle(2);
      chk("t2_first_add", int'(key_code), 10);
      pop_one();
      chk("t2_second_eq", int'(key_code), 14);
      pop_one();
      chk("t2_empty", int'(key_valid), 0);

      // Five makes into a 4-deep FIFO.
      for (int i = 0; i < 5; i++) send(8'h45);
      idle(2);
      chk("t3_overflow", int'(overflow), 1);
      for (int i = 0; i < 4; i++) begin
         chk("t3_entry_code", int'(key_code), 0);
         chk("t3_entry_valid", int'(key_valid), 1);
         pop_one();
      end
      chk("t3_drained", int'(key_valid), 0);
      chk("t3_overflow_sticky", int'(overflow), 1);

      // Full FIFO, pop and push in the same cycle.
      do_reset();
      send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
      idle(2);
      send(8'h36);
      key_ready = 1'b1;
      @(posedge clk);
      #1;
      key_ready = 1'b0;
      chk("t4_no_overflow", int'(overflow), 0);
      for (int i = 3; i <= 6; i++) begin
         chk("t4_order", int'(key_code), i);
         pop_one();
      end
      chk("t4_drained", int'(key_valid), 0);

      // Extended Enter.
      send(8'hE0); send(8'h5A);
      idle(2);
`ifdef PS2_DEC_NUMPAD_EN
      chk("t5_ext_eq", int'(key_code), 14);
      pop_one();
`else
      chk("t5_ext_dropped", int'(key_valid), 0);
`endif
      send(8'h1E);
      idle(1);
      chk("t5_after_ext", int'(key_code), 2);
      pop_one();

      // Reset while in the middle of a release.
      send(8'hF0);
      do_reset();
      send(8'h26);
      idle(1);
      chk("t6_valid", int'(key_valid), 1);
      chk("t6_code", int'(key_code), 3);
      pop_one();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         code_valid = ($urandom_range(0, 1) != 0);
         code_data  = pick_byte();
         key_ready  = ($urandom_range(0, 9) < 4);
         rst        = ((c % 700) == 699);
         @(posedge clk);
         #1;
      end
      rst        = 1'b0;
      code_valid = 1'b0;
      key_ready  = 1'b1;
      idle(DEPTH + 4);
      chk("final_drained", int'(key_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
